// File: rtl/loader_pkg.sv
// Shared types for the boot-time program loader: FSM states, segment header layout and the
// default IMem fill word.
package loader_pkg;

    typedef enum logic [2:0] {
        CLEAR,
        HEADER,
        PAYLOAD,
        RELEASE,
        RUN
    } loader_state_e;

    typedef struct packed {
        logic        last;
        logic        tgt;
        logic [13:0] count;
        logic [15:0] base;
    } loader_hdr_t;

    localparam logic [31:0] LOADER_NOP_WORD = 32'h0000_0013;

endpackage

// File: rtl/program_loader.sv
// Boot loader: holds the core in reset, fills IMem with NOPs, then streams segmented words from
// a valid/ready source into the IMem/DMem write ports before releasing the core.
module program_loader
    import loader_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = 256,
    parameter int unsigned DMEM_DEPTH = 256,
    parameter logic [31:0] NOP_WORD   = LOADER_NOP_WORD,
    parameter int unsigned RESET_HOLD = 2,
    localparam int unsigned IMEM_AW   = $clog2(IMEM_DEPTH),
    localparam int unsigned DMEM_AW   = $clog2(DMEM_DEPTH)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_data,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [31:0]        imem_wdata,
    output logic               dmem_we,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [31:0]        dmem_wdata,
    output logic               cpu_reset,
    output logic               load_done,
    output logic               load_error,
    output logic [15:0]        words_loaded
);

    localparam int unsigned HOLD_W = (RESET_HOLD < 1) ? 1 : $clog2(RESET_HOLD + 1);

    loader_state_e      state_q, state_d;
    loader_hdr_t        hdr_q, hdr_d;
    loader_hdr_t        hdr_in;
    logic [IMEM_AW-1:0] clear_idx_q, clear_idx_d;
    logic [13:0]        off_q, off_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               fill_q, fill_d;
    logic               imem_we_q, imem_we_d;
    logic               dmem_we_q, dmem_we_d;
    logic [IMEM_AW-1:0] imem_addr_q, imem_addr_d;
    logic [DMEM_AW-1:0] dmem_addr_q, dmem_addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               err_q, err_d;
    logic [15:0]        words_q, words_d;
    logic [16:0]        addr17;
    logic               accept;

    // fill_q masks in_ready while the last registered NOP write is still on the port.
    assign in_ready = ((state_q == HEADER) || (state_q == PAYLOAD)) && !fill_q;
    assign accept   = in_valid && in_ready;
    assign hdr_in   = loader_hdr_t'(in_data);
    assign addr17   = {1'b0, hdr_q.base} + {3'b000, off_q};

    always_comb begin
        state_d     = state_q;
        hdr_d       = hdr_q;
        clear_idx_d = clear_idx_q;
        off_d       = off_q;
        hold_d      = '0;
        fill_d      = (state_q == CLEAR);
        imem_we_d   = 1'b0;
        dmem_we_d   = 1'b0;
        imem_addr_d = imem_addr_q;
        dmem_addr_d = dmem_addr_q;
        wdata_d     = wdata_q;
        err_d       = err_q;
        words_d     = words_q;

        unique case (state_q)
            CLEAR: begin
                imem_we_d   = 1'b1;
                imem_addr_d = clear_idx_q;
                wdata_d     = NOP_WORD;
                clear_idx_d = clear_idx_q + IMEM_AW'(1);
                if (clear_idx_q == IMEM_AW'(IMEM_DEPTH - 1)) begin
                    state_d = HEADER;
                end
            end
            HEADER: begin
                if (accept) begin
                    hdr_d = hdr_in;
                    off_d = '0;
                    if (hdr_in.count != '0) begin
                        state_d = PAYLOAD;
                    end else if (hdr_in.last) begin
                        state_d = RELEASE;
                    end
                end
            end
            PAYLOAD: begin
                if (accept) begin
                    wdata_d = in_data;
                    if (hdr_q.tgt ? (addr17 < 17'(DMEM_DEPTH)) : (addr17 < 17'(IMEM_DEPTH))) begin
                        imem_we_d   = !hdr_q.tgt;
                        dmem_we_d   = hdr_q.tgt;
                        imem_addr_d = addr17[IMEM_AW-1:0];
                        dmem_addr_d = addr17[DMEM_AW-1:0];
                        if (words_q != 16'hFFFF) begin
                            words_d = words_q + 16'd1;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                    off_d = off_q + 14'd1;
                    if (off_q == hdr_q.count - 14'd1) begin
                        state_d = hdr_q.last ? RELEASE : HEADER;
                    end
                end
            end
            RELEASE: begin
                // Entered in the cycle of the final strobe; hold spans the cycles after it.
                if (hold_q == HOLD_W'(RESET_HOLD)) begin
                    state_d = RUN;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= CLEAR;
            hdr_q       <= '0;
            clear_idx_q <= '0;
            off_q       <= '0;
            hold_q      <= '0;
            fill_q      <= 1'b0;
            imem_we_q   <= 1'b0;
            dmem_we_q   <= 1'b0;
            imem_addr_q <= '0;
            dmem_addr_q <= '0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
            words_q     <= '0;
        end else begin
            state_q     <= state_d;
            hdr_q       <= hdr_d;
            clear_idx_q <= clear_idx_d;
            off_q       <= off_d;
            hold_q      <= hold_d;
            fill_q      <= fill_d;
            imem_we_q   <= imem_we_d;
            dmem_we_q   <= dmem_we_d;
            imem_addr_q <= imem_addr_d;
            dmem_addr_q <= dmem_addr_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
            words_q     <= words_d;
        end
    end

    assign imem_we      = imem_we_q;
    assign imem_addr    = imem_addr_q;
    assign imem_wdata   = wdata_q;
    assign dmem_we      = dmem_we_q;
    assign dmem_addr    = dmem_addr_q;
    assign dmem_wdata   = wdata_q;
    assign cpu_reset    = (state_q != RUN);
    assign load_done    = (state_q == RUN);
    assign load_error   = err_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: table-driven boots, randomized multi-segment boots
// against a memory-image reference model, and hand sequences for fill and mid-load reset.
module tb_program_loader;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        imem_we, dmem_we;
    logic [7:0]  imem_addr, dmem_addr;
    logic [31:0] imem_wdata, dmem_wdata;
    logic        cpu_reset, load_done, load_error;
    logic [15:0] words_loaded;

    program_loader #(
        .IMEM_DEPTH(256),
        .DMEM_DEPTH(256),
        .NOP_WORD  (NOP),
        .RESET_HOLD(2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .cpu_reset   (cpu_reset),
        .load_done   (load_done),
        .load_error  (load_error),
        .words_loaded(words_loaded)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clock) cyc++;

    // Observed memory images (from strobes) and the reference model's images.
    logic [31:0] imem_o[256];
    logic [31:0] dmem_o[256];
    logic [31:0] imem_m[256];
    logic [31:0] dmem_m[256];
    int          n_strobe, viol, last_strobe_cyc, run_cyc, last_acc;
    int          exp_n;
    bit          exp_err;
    logic [31:0] stream[$];

    typedef struct {
        logic [31:0] hdr_a;
        logic [31:0] hdr_b;
        int          exp_words;
        bit          exp_err;
        bit          timing;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (imem_we && dmem_we) viol++;
            if ((imem_we || dmem_we) && load_done) viol++;
            if (imem_we) begin
                imem_o[imem_addr] = imem_wdata;
                n_strobe++;
                last_strobe_cyc = cyc;
            end
            if (dmem_we) begin
                dmem_o[dmem_addr] = dmem_wdata;
                n_strobe++;
                last_strobe_cyc = cyc;
            end
            if (!cpu_reset && run_cyc < 0) run_cyc = cyc;
        end
    end

    task automatic clear_obs();
        for (int i = 0; i < 256; i++) begin
            imem_o[i] = '0;
            dmem_o[i] = '0;
            imem_m[i] = NOP;
            dmem_m[i] = '0;
        end
        n_strobe = 0;
        viol = 0;
        last_strobe_cyc = -1;
        run_cyc = -1;
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1;
        in_valid = 1'b0;
        clear_obs();
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    // Reference: walk the stream as headers and payloads, plain integer addresses, no wrap.
    task automatic model_run();
        int idx = 0;
        exp_n = 0;
        exp_err = 1'b0;
        while (idx < stream.size()) begin
            logic [31:0] h = stream[idx];
            int cnt = int'(h[29:16]);
            int base = int'(h[15:0]);
            idx++;
            for (int i = 0; i < cnt; i++) begin
                int a = base + i;
                if (a < 256) begin
                    if (h[30]) dmem_m[a] = stream[idx];
                    else imem_m[a] = stream[idx];
                    exp_n++;
                end else begin
                    exp_err = 1'b1;
                end
                idx++;
            end
            if (h[31]) break;
        end
    endtask

    task automatic send(input logic [31:0] w, input bit gaps);
        int n = 0;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                in_valid = 1'b0;
                in_data = $urandom;
                @(negedge clock);
            end
        end
        in_valid = 1'b1;
        in_data = w;
        while (!in_ready && n < 400) begin
            @(negedge clock);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: in_ready got 0 expected 1 within 400 cycles");
            in_valid = 1'b0;
        end else begin
            last_acc = cyc + 1;
            @(negedge clock);
            in_valid = 1'b0;
        end
    endtask

    task automatic run_boot(input string tag, input bit gaps, input bit timing);
        int n = 0;
        int bad_i = 0;
        int bad_d = 0;
        apply_reset();
        model_run();
        foreach (stream[i]) send(stream[i], gaps);
        while (!load_done && n < 100) begin
            @(negedge clock);
            n++;
        end
        repeat (3) @(negedge clock);
        for (int i = 0; i < 256; i++) begin
            if (imem_o[i] !== imem_m[i]) bad_i++;
            if (dmem_o[i] !== dmem_m[i]) bad_d++;
        end
        check({tag, "_load_done"}, load_done, 1);
        check({tag, "_cpu_reset"}, cpu_reset, 0);
        check({tag, "_words_loaded"}, words_loaded, exp_n);
        check({tag, "_load_error"}, load_error, exp_err);
        check({tag, "_strobe_count"}, n_strobe, 256 + exp_n);
        check({tag, "_strobe_rules"}, viol, 0);
        check({tag, "_imem_image_bad"}, bad_i, 0);
        check({tag, "_dmem_image_bad"}, bad_d, 0);
        if (timing) begin
            check({tag, "_strobe_latency"}, last_strobe_cyc, last_acc);
            check({tag, "_release_hold"}, run_cyc - last_strobe_cyc, 3);
        end
    endtask

    task automatic build_vec(input vec_t v);
        stream.delete();
        stream.push_back(v.hdr_a);
        repeat (int'(v.hdr_a[29:16])) stream.push_back($urandom);
        if (!v.hdr_a[31]) begin
            stream.push_back(v.hdr_b);
            repeat (int'(v.hdr_b[29:16])) stream.push_back($urandom);
        end
    endtask

    initial begin
        int n;
        int bad;
        vecs[0] = '{32'h8002_0000, 32'h0, 2, 1'b0, 1'b1};
        vecs[1] = '{32'h0003_0000, 32'hC001_0000, 4, 1'b0, 1'b1};
        vecs[2] = '{32'h8002_00FF, 32'h0, 1, 1'b1, 1'b0};
        vecs[3] = '{32'hC003_00FE, 32'h0, 2, 1'b1, 1'b0};
        vecs[4] = '{32'h8000_0000, 32'h0, 0, 1'b0, 1'b0};
        vecs[5] = '{32'hC002_FFFF, 32'h0, 0, 1'b1, 1'b0};
        vecs[6] = '{32'h0000_0000, 32'h8001_0005, 1, 1'b0, 1'b0};
        vecs[7] = '{32'h0002_0010, 32'h8002_0011, 4, 1'b0, 1'b0};

        // Reset values, then the full NOP fill sweep.
        clear_obs();
        repeat (2) @(negedge clock);
        check("rst_cpu_reset", cpu_reset, 1);
        check("rst_in_ready", in_ready, 0);
        check("rst_strobes", {imem_we, dmem_we}, 0);
        check("rst_load_done", load_done, 0);
        check("rst_err_words", {load_error, words_loaded}, 0);
        reset = 1'b0;
        n = 0;
        while (!imem_we && n < 10) begin
            @(negedge clock);
            n++;
        end
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (!imem_we || imem_addr !== 8'(i) || imem_wdata !== NOP || !cpu_reset || in_ready)
                bad++;
            @(negedge clock);
        end
        check("clear_sweep_bad", bad, 0);
        check("clear_end_we", imem_we, 0);
        check("clear_end_ready", in_ready, 1);

        foreach (vecs[i]) begin
            build_vec(vecs[i]);
            run_boot($sformatf("vec%0d", i), !vecs[i].timing && (i % 2 == 1), vecs[i].timing);
            check($sformatf("vec%0d_tbl_words", i), words_loaded, vecs[i].exp_words);
            check($sformatf("vec%0d_tbl_err", i), load_error, vecs[i].exp_err);
        end

        // Random multi-segment programs with random in_valid gaps.
        for (int r = 0; r < 8; r++) begin
            int nseg = $urandom_range(1, 4);
            stream.delete();
            for (int s = 0; s < nseg; s++) begin
                logic [31:0] h;
                int cnt = $urandom_range(0, 6);
                int base = ($urandom_range(0, 3) == 0) ? $urandom_range(250, 260)
                                                       : $urandom_range(0, 255);
                h = {(s == nseg - 1) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)), 14'(cnt), 16'(base)};
                stream.push_back(h);
                repeat (cnt) stream.push_back($urandom);
            end
            run_boot($sformatf("rand%0d", r), 1'b1, 1'b0);
        end

        // Reset in the middle of a payload segment, after an error was flagged.
        apply_reset();
        send(32'h0002_00FF, 1'b0);
        send($urandom, 1'b0);
        send($urandom, 1'b0);
        send(32'h000A_0000, 1'b0);
        repeat (3) send($urandom, 1'b0);
        check("mid_pre_err", load_error, 1);
        check("mid_pre_strobe", imem_we, 1);
        #1 reset = 1'b1;
        #1;
        check("mid_cpu_reset", cpu_reset, 1);
        check("mid_strobe_killed", {imem_we, dmem_we}, 0);
        check("mid_err_cleared", load_error, 0);
        check("mid_words_cleared", words_loaded, 0);
        bad = 0;
        repeat (3) begin
            @(negedge clock);
            if (imem_we || dmem_we) bad++;
        end
        check("mid_no_strobe_in_reset", bad, 0);
        reset = 1'b0;
        n = 0;
        while (!imem_we && n < 10) begin
            @(negedge clock);
            n++;
        end
        check("mid_restart_addr", imem_addr, 0);
        check("mid_restart_data", imem_wdata, NOP);
        check("mid_restart_err", load_error, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
